// File: rtl/iomem_bus_ctrl.sv
// Registered PicoSoC iomem bus controller: decodes CPU requests onto four peripheral slots.
// Define IOMEM_TIMEOUT_EN to build the ACCESS timeout counter and err_irq/err_addr reporting.
module iomem_bus_ctrl #(
    parameter logic [31:0] SLOT_IDS       = 32'h07_05_04_03,
    parameter int          TIMEOUT_CYCLES = 255
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         m_valid,
    input  logic [31:0]  m_addr,
    input  logic [3:0]   m_wstrb,
    input  logic [31:0]  m_wdata,
    output logic         m_ready,
    output logic [31:0]  m_rdata,
    output logic [3:0]   s_valid,
    output logic [31:0]  s_addr,
    output logic [3:0]   s_wstrb,
    output logic [31:0]  s_wdata,
    input  logic [3:0]   s_ready,
    input  logic [127:0] s_rdata,
    output logic         err_irq,
    output logic [31:0]  err_addr
);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t      r_state;
    state_t      w_nextState;
    logic [1:0]  r_slot;
    logic [1:0]  w_hitSlot;
    logic        w_hit;
    logic        w_slotReady;
    logic [31:0] w_slotData;
    logic        w_timeout;

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_badTimeout
        $error("TIMEOUT_CYCLES must be in 1..65535");
    end

    // Descending scan so the lowest-numbered slot wins if two IDs collide.
    always_comb begin
        w_hit     = 1'b0;
        w_hitSlot = 2'd0;
        for (int n = 3; n >= 0; n--) begin
            if (m_addr[31:24] == SLOT_IDS[8*n +: 8]) begin
                w_hit     = 1'b1;
                w_hitSlot = 2'(n);
            end
        end
    end

    assign w_slotReady = s_ready[r_slot];
    assign w_slotData  = s_rdata[{r_slot, 5'b00000} +: 32];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (m_valid) w_nextState = w_hit ? ACCESS : DONE;
            ACCESS:  if (w_slotReady || w_timeout) w_nextState = DONE;
            DONE:    w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_slot  <= 2'd0;
            s_valid <= 4'b0000;
            s_addr  <= 32'h0;
            s_wstrb <= 4'h0;
            s_wdata <= 32'h0;
            m_ready <= 1'b0;
            m_rdata <= 32'h0;
        end else begin
            m_ready <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (m_valid) begin
                        s_addr  <= m_addr;
                        s_wstrb <= m_wstrb;
                        s_wdata <= m_wdata;
                        if (w_hit) begin
                            r_slot  <= w_hitSlot;
                            s_valid <= 4'b0001 << w_hitSlot;
                        end else begin
                            m_rdata <= 32'h0;
                            m_ready <= 1'b1;
                        end
                    end
                end
                ACCESS: begin
                    // A slave answering in the final allowed cycle beats the timeout.
                    if (w_slotReady) begin
                        m_rdata <= w_slotData;
                        s_valid <= 4'b0000;
                        m_ready <= 1'b1;
                    end else if (w_timeout) begin
                        m_rdata <= 32'hFFFF_FFFF;
                        s_valid <= 4'b0000;
                        m_ready <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef IOMEM_TIMEOUT_EN
    logic [15:0] r_count;

    assign w_timeout = (r_state == ACCESS) && !w_slotReady &&
                       (r_count == 16'(TIMEOUT_CYCLES - 1));

    // Counter idles at zero, so it is already cleared on entry to ACCESS.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count  <= 16'h0;
            err_irq  <= 1'b0;
            err_addr <= 32'h0;
        end else begin
            err_irq <= w_timeout;
            if (w_timeout) begin
                err_addr <= s_addr;
            end
            if (r_state == ACCESS) begin
                r_count <= r_count + 16'h1;
            end else begin
                r_count <= 16'h0;
            end
        end
    end
`else
    assign w_timeout = 1'b0;
    assign err_irq   = 1'b0;
    assign err_addr  = 32'h0;
`endif

endmodule

// File: tb/tb_iomem_bus_ctrl.sv
// Directed self-checking bench for iomem_bus_ctrl; timeout cases run only when IOMEM_TIMEOUT_EN is defined.
module tb_iomem_bus_ctrl;

    logic         clk = 1'b0;
    logic         reset;
    logic         m_valid;
    logic [31:0]  m_addr;
    logic [3:0]   m_wstrb;
    logic [31:0]  m_wdata;
    logic         m_ready;
    logic [31:0]  m_rdata;
    logic [3:0]   s_valid;
    logic [31:0]  s_addr;
    logic [3:0]   s_wstrb;
    logic [31:0]  s_wdata;
    logic [3:0]   s_ready;
    logic [127:0] s_rdata;
    logic         err_irq;
    logic [31:0]  err_addr;

    int checks = 0;
    int errors = 0;

    int          slaveWait;
    int          svCount;
    logic [3:0]  junkReady;

    int          obsFirstValid;
    int          obsValidCycles;
    logic [3:0]  obsValidVal;
    int          obsReadyCycle;
    int          obsReadyPulses;
    logic [31:0] obsRdata;
    int          obsIrqPulses;
    int          obsIrqCycle;

    iomem_bus_ctrl #(
        .SLOT_IDS       (32'h07_05_04_03),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .m_valid  (m_valid),
        .m_addr   (m_addr),
        .m_wstrb  (m_wstrb),
        .m_wdata  (m_wdata),
        .m_ready  (m_ready),
        .m_rdata  (m_rdata),
        .s_valid  (s_valid),
        .s_addr   (s_addr),
        .s_wstrb  (s_wstrb),
        .s_wdata  (s_wdata),
        .s_ready  (s_ready),
        .s_rdata  (s_rdata),
        .err_irq  (err_irq),
        .err_addr (err_addr)
    );

    always #5 clk = ~clk;

    // Slave model: selected slot answers after slaveWait wait cycles.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            svCount <= 0;
        end else if (s_valid == 4'b0000) begin
            svCount <= 0;
        end else begin
            svCount <= svCount + 1;
        end
    end

    assign s_ready = ((s_valid != 4'b0000 && svCount >= slaveWait) ? s_valid : 4'b0000) | junkReady;
    assign s_rdata = {32'hC0DE_0007, 32'h5A5A_0005, 32'h4444_1111, 32'h0000_00A5};

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] addr, input logic [3:0] wstrb,
                                 input logic [31:0] wdata, input int waitCycles);
        @(negedge clk);
        m_valid        = 1'b1;
        m_addr         = addr;
        m_wstrb        = wstrb;
        m_wdata        = wdata;
        slaveWait      = waitCycles;
        obsFirstValid  = -1;
        obsValidCycles = 0;
        obsValidVal    = 4'b0000;
        obsReadyCycle  = -1;
        obsReadyPulses = 0;
        obsRdata       = 32'h0;
        obsIrqPulses   = 0;
        obsIrqCycle    = -1;
        for (int cyc = 1; cyc <= 300; cyc++) begin
            @(posedge clk);
            #1;
            if (s_valid != 4'b0000) begin
                if (obsFirstValid < 0) begin
                    obsFirstValid = cyc;
                    obsValidVal   = s_valid;
                end
                obsValidCycles++;
            end
            if (m_ready) begin
                obsReadyPulses++;
                if (obsReadyCycle < 0) begin
                    obsReadyCycle = cyc;
                    obsRdata      = m_rdata;
                end
                m_valid = 1'b0;
            end
            if (err_irq) begin
                obsIrqPulses++;
                obsIrqCycle = cyc;
            end
            if (obsReadyCycle > 0 && cyc >= obsReadyCycle + 2) break;
        end
        m_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset     = 1'b1;
        m_valid   = 1'b0;
        m_addr    = 32'h0;
        m_wstrb   = 4'h0;
        m_wdata   = 32'h0;
        slaveWait = 0;
        junkReady = 4'b0000;

        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_m_ready",  32'(m_ready),  32'h0);
        checkOutput("rst_m_rdata",  m_rdata,       32'h0);
        checkOutput("rst_s_valid",  32'(s_valid),  32'h0);
        checkOutput("rst_s_addr",   s_addr,        32'h0);
        checkOutput("rst_err_irq",  32'(err_irq),  32'h0);
        checkOutput("rst_err_addr", err_addr,      32'h0);
        @(negedge clk);
        reset = 1'b0;

        $display("[TB] GPIO read, slot 0");
        applyStimulus(32'h0300_0004, 4'h0, 32'h0, 0);
        checkOutput("gpio_valid_cycle",  32'(obsFirstValid),  32'd1);
        checkOutput("gpio_valid_val",    32'(obsValidVal),    32'h1);
        checkOutput("gpio_valid_len",    32'(obsValidCycles), 32'd1);
        checkOutput("gpio_ready_cycle",  32'(obsReadyCycle),  32'd2);
        checkOutput("gpio_ready_pulses", 32'(obsReadyPulses), 32'd1);
        checkOutput("gpio_rdata",        obsRdata,            32'h0000_00A5);
        checkOutput("gpio_s_addr",       s_addr,              32'h0300_0004);

        $display("[TB] Video write, slot 2, three wait cycles");
        applyStimulus(32'h0500_0010, 4'hF, 32'h1234_5678, 3);
        checkOutput("video_s_wdata",      s_wdata,             32'h1234_5678);
        checkOutput("video_s_wstrb",      32'(s_wstrb),        32'hF);
        checkOutput("video_s_addr",       s_addr,              32'h0500_0010);
        checkOutput("video_valid_val",    32'(obsValidVal),    32'h4);
        checkOutput("video_valid_len",    32'(obsValidCycles), 32'd4);
        checkOutput("video_ready_cycle",  32'(obsReadyCycle),  32'd5);
        checkOutput("video_ready_pulses", 32'(obsReadyPulses), 32'd1);
        checkOutput("video_rdata",        obsRdata,            32'h5A5A_0005);

        $display("[TB] Audio read, slot 1, with a stray ready on slot 0");
        junkReady = 4'b0001;
        applyStimulus(32'h0400_0000, 4'h0, 32'h0, 2);
        junkReady = 4'b0000;
        checkOutput("audio_valid_val",   32'(obsValidVal),    32'h2);
        checkOutput("audio_valid_len",   32'(obsValidCycles), 32'd3);
        checkOutput("audio_ready_cycle", 32'(obsReadyCycle),  32'd4);
        checkOutput("audio_rdata",       obsRdata,            32'h4444_1111);

        $display("[TB] Unmapped read");
        applyStimulus(32'h0600_0000, 4'h0, 32'h0, 0);
        checkOutput("unmap_valid_len",    32'(obsValidCycles), 32'd0);
        checkOutput("unmap_ready_cycle",  32'(obsReadyCycle),  32'd1);
        checkOutput("unmap_ready_pulses", 32'(obsReadyPulses), 32'd1);
        checkOutput("unmap_rdata",        obsRdata,            32'h0);
        checkOutput("unmap_s_addr",       s_addr,              32'h0600_0000);

`ifdef IOMEM_TIMEOUT_EN
        $display("[TB] I2C timeout");
        applyStimulus(32'h0700_0000, 4'h0, 32'h0, 1000);
        checkOutput("tmo_valid_val",   32'(obsValidVal),    32'h8);
        checkOutput("tmo_valid_len",   32'(obsValidCycles), 32'd8);
        checkOutput("tmo_ready_cycle", 32'(obsReadyCycle),  32'd9);
        checkOutput("tmo_rdata",       obsRdata,            32'hFFFF_FFFF);
        checkOutput("tmo_irq_pulses",  32'(obsIrqPulses),   32'd1);
        checkOutput("tmo_irq_cycle",   32'(obsIrqCycle),    32'd9);
        checkOutput("tmo_err_addr",    err_addr,            32'h0700_0000);

        $display("[TB] I2C timeout race");
        applyStimulus(32'h0700_0000, 4'h0, 32'h0, 7);
        checkOutput("race_valid_len",   32'(obsValidCycles), 32'd8);
        checkOutput("race_ready_cycle", 32'(obsReadyCycle),  32'd9);
        checkOutput("race_rdata",       obsRdata,            32'hC0DE_0007);
        checkOutput("race_irq_pulses",  32'(obsIrqPulses),   32'd0);
        checkOutput("race_err_addr",    err_addr,            32'h0700_0000);
`else
        $display("[TB] I2C slow slave without timeout");
        applyStimulus(32'h0700_0000, 4'h0, 32'h0, 20);
        checkOutput("slow_valid_val",   32'(obsValidVal),    32'h8);
        checkOutput("slow_valid_len",   32'(obsValidCycles), 32'd21);
        checkOutput("slow_ready_cycle", 32'(obsReadyCycle),  32'd22);
        checkOutput("slow_rdata",       obsRdata,            32'hC0DE_0007);
        checkOutput("slow_irq_pulses",  32'(obsIrqPulses),   32'd0);
        checkOutput("slow_err_addr",    err_addr,            32'h0);
`endif

        $display("[TB] Reset during ACCESS");
        @(negedge clk);
        m_valid   = 1'b1;
        m_addr    = 32'h0300_0008;
        m_wstrb   = 4'h3;
        m_wdata   = 32'hDEAD_BEEF;
        slaveWait = 10;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        checkOutput("mid_s_valid_before", 32'(s_valid), 32'h1);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("mid_s_valid",  32'(s_valid), 32'h0);
        checkOutput("mid_m_ready",  32'(m_ready), 32'h0);
        checkOutput("mid_m_rdata",  m_rdata,      32'h0);
        checkOutput("mid_s_addr",   s_addr,       32'h0);
        checkOutput("mid_s_wstrb",  32'(s_wstrb), 32'h0);
        checkOutput("mid_s_wdata",  s_wdata,      32'h0);
        checkOutput("mid_err_irq",  32'(err_irq), 32'h0);
        checkOutput("mid_err_addr", err_addr,     32'h0);
        @(negedge clk);
        m_valid   = 1'b0;
        slaveWait = 0;
        reset     = 1'b0;

        applyStimulus(32'h0300_0004, 4'h0, 32'h0, 0);
        checkOutput("post_ready_cycle", 32'(obsReadyCycle), 32'd2);
        checkOutput("post_rdata",       obsRdata,           32'h0000_00A5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
